// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_rx
// Description : UART host-command receiver for the frequency meter. Decodes
//               ASCII '0'..'3' into a 2-bit opcode and presents it through a
//               one-entry valid/ready buffer. Default framing is 8N1; define
//               UART_CMD_RX_PARITY_EN for 8E1 (even parity checked).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    input  logic       cmd_ready,
    output logic [1:0] opcode,
    output logic       cmd_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       bad_cmd,
    output logic       overflow
);

    localparam int              c_cw      = $clog2(CLKS_PER_BIT);
    localparam logic [c_cw-1:0] c_full_m1 = c_cw'(CLKS_PER_BIT - 1);
    localparam logic [c_cw-1:0] c_half_m1 = c_cw'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_stop   = 3'd4;
    localparam logic [2:0] c_st_wait   = 3'd5;
`ifdef UART_CMD_RX_PARITY_EN
    localparam logic [2:0] c_st_parity = 3'd3;
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic                   w_rx_s;
    logic                   w_fall;

    logic [2:0]      r_state;
    logic [c_cw-1:0] r_baud;
    logic [c_cw-1:0] w_baud_nxt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_busy;
    logic            r_ferr;
    logic            r_rx_done;
    logic            w_par_ok;

    logic            w_in_rng;
    logic            r_dec_wr;
    logic [1:0]      r_dec_op;
    logic            r_bad;

    logic            r_valid;
    logic [1:0]      r_op;
    logic            r_ovf;

    assign w_rx_s     = r_sync[SYNC_STAGES-1];
    assign w_fall     = r_rx_prev & ~w_rx_s;
    assign w_baud_nxt = (r_baud == c_full_m1) ? r_baud : r_baud + 1'b1;
    assign w_in_rng   = (r_shift[7:2] == 6'b001100);

`ifdef UART_CMD_RX_PARITY_EN
    logic r_par_bad;
    assign w_par_ok = ~r_par_bad;
`else
    assign w_par_ok = 1'b1;
`endif

    // Synchronise RxD; cleared low so a line held low through reset is never taken as a falling edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_rx_prev <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], RxD};
            r_rx_prev <= w_rx_s;
        end
    end

    // Frame receiver: start/data/(parity)/stop sampling at mid-bit, break recovery in WAIT_IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_busy    <= 1'b0;
            r_ferr    <= 1'b0;
            r_rx_done <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_ferr    <= 1'b0;
            r_rx_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_baud    <= '0;
                    r_bit_cnt <= '0;
                    if (w_fall) begin
                        r_state <= c_st_start;
                        r_busy  <= 1'b1;
                    end
                end
                c_st_start: begin
                    if (r_baud == c_half_m1) begin
                        r_baud <= '0;
                        if (w_rx_s) begin
                            // Line went back high before mid start bit: a glitch
                            r_state <= c_st_idle;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= c_st_data;
                        end
                    end else begin
                        r_baud <= w_baud_nxt;
                    end
                end
                c_st_data: begin
                    if (r_baud == c_full_m1) begin
                        r_baud    <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
                            r_state <= c_st_parity;
`else
                            r_state <= c_st_stop;
`endif
                        end
                    end else begin
                        r_baud <= w_baud_nxt;
                    end
                end
`ifdef UART_CMD_RX_PARITY_EN
                c_st_parity: begin
                    if (r_baud == c_full_m1) begin
                        r_baud    <= '0;
                        // Even parity: data plus parity bit must hold an even number of ones
                        r_par_bad <= w_rx_s ^ (^r_shift);
                        r_state   <= c_st_stop;
                    end else begin
                        r_baud <= w_baud_nxt;
                    end
                end
`endif
                c_st_stop: begin
                    if (r_baud == c_full_m1) begin
                        r_baud <= '0;
                        if (w_rx_s && w_par_ok) begin
                            r_rx_done <= 1'b1;
                            r_state   <= c_st_idle;
                            r_busy    <= 1'b0;
                        end else begin
                            r_ferr <= 1'b1;
                            if (w_rx_s) begin
                                r_state <= c_st_idle;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= c_st_wait;
                            end
                        end
                    end else begin
                        r_baud <= w_baud_nxt;
                    end
                end
                c_st_wait: begin
                    r_baud <= '0;
                    if (w_rx_s) begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                    r_baud  <= '0;
                end
            endcase
        end
    end

    // Decode the received byte on the cycle after the stop sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dec_wr <= 1'b0;
            r_dec_op <= 2'b00;
            r_bad    <= 1'b0;
        end else begin
            r_dec_wr <= r_rx_done & w_in_rng;
            r_bad    <= r_rx_done & ~w_in_rng;
            if (r_rx_done) begin
                r_dec_op <= r_shift[1:0];
            end
        end
    end

    // One-entry opcode buffer: a write while full is dropped unless the old entry leaves that same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_op    <= 2'b00;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (r_dec_wr) begin
                if (r_valid && !cmd_ready) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_op    <= r_dec_op;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && cmd_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign opcode    = r_op;
    assign cmd_valid = r_valid;
    assign busy      = r_busy;
    assign frame_err = r_ferr;
    assign bad_cmd   = r_bad;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_rx
// Description : Self-checking bench for uart_cmd_rx: table of frames with
//               hand-derived expectations, randomized frames against a
//               transaction-level model, plus glitch/reset/parity sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_rx;

    localparam int CPB = 16;
`ifdef UART_CMD_RX_PARITY_EN
    localparam int c_nbits = 11;
    localparam bit c_par   = 1'b1;
`else
    localparam int c_nbits = 10;
    localparam bit c_par   = 1'b0;
`endif
    localparam int c_flen     = c_nbits * CPB;
    // Drive at negedge 0 -> two sync flops -> edge detect -> half bit -> whole bits
    localparam int c_stop_idx = 3 + CPB / 2 + CPB * (c_nbits - 1);
    localparam int c_gap      = 8;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       RxD       = 1'b1;
    logic       cmd_ready = 1'b0;
    logic [1:0] opcode;
    logic       cmd_valid;
    logic       busy;
    logic       frame_err;
    logic       bad_cmd;
    logic       overflow;

    uart_cmd_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .RxD(RxD), .cmd_ready(cmd_ready),
        .opcode(opcode), .cmd_valid(cmd_valid), .busy(busy),
        .frame_err(frame_err), .bad_cmd(bad_cmd), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         stopb;
        bit         badpar;
        bit         ready;
        int         hold;
        int         rdy_k;
        bit         consume;
        bit         e_ferr;
        bit         e_bad;
        bit         e_ovf;
        bit         e_rise;
        bit         e_valid;
        logic [1:0] e_op;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         m_valid  = 1'b0;
    logic [1:0] m_op     = 2'b00;
    vec_t       tbl[10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] d, input bit s, input bit bp, input bit rdy,
                                input int hold, input int rk, input bit cons,
                                input bit ef, input bit eb, input bit eo, input bit er,
                                input bit ev, input logic [1:0] eop);
        vec_t v;
        v.data = d; v.stopb = s; v.badpar = bp; v.ready = rdy; v.hold = hold;
        v.rdy_k = rk; v.consume = cons; v.e_ferr = ef; v.e_bad = eb; v.e_ovf = eo;
        v.e_rise = er; v.e_valid = ev; v.e_op = eop;
        return v;
    endfunction

    // Transaction-level reference: one frame in, buffer contents and pulses out
    function automatic vec_t model(input vec_t v);
        bit good;
        bit wr;
        good     = v.stopb && !(c_par && v.badpar);
        wr       = good && (v.data >= 8'h30) && (v.data <= 8'h33);
        v.e_ferr = !good;
        v.e_bad  = good && !wr;
        if (m_valid && v.ready) m_valid = 1'b0;
        v.e_ovf  = wr && m_valid;
        v.e_rise = wr && !m_valid;
        if (v.e_rise) begin
            m_op    = v.data[1:0];
            m_valid = 1'b1;
        end
        if (m_valid && v.ready) m_valid = 1'b0;
        v.e_valid = m_valid;
        v.e_op    = m_op;
        if (v.consume) m_valid = 1'b0;
        return v;
    endfunction

    function automatic logic bitval(input vec_t v, input int k);
        int idx;
        idx = k / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return v.data[idx-1];
        if (c_par && idx == 9) return (^v.data) ^ v.badpar;
        if (idx == c_nbits - 1) return v.stopb;
        if (k < c_flen + v.hold) return 1'b0;
        return 1'b1;
    endfunction

    // 0 pulses -> -1, one pulse -> its cycle index, several -> 1000+count
    function automatic int pulse_sig(input int n, input int idx);
        return (n == 0) ? -1 : ((n == 1) ? idx : 1000 + n);
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int   n_f = 0, n_b = 0, n_o = 0;
        int   i_f = -1, i_b = -1, i_o = -1, i_r = -1;
        logic pv;
        cmd_ready = v.ready;
        pv = cmd_valid;
        for (int k = 0; k < c_flen + v.hold + c_gap; k++) begin
            if (frame_err) begin n_f++; if (i_f < 0) i_f = k; end
            if (bad_cmd)   begin n_b++; if (i_b < 0) i_b = k; end
            if (overflow)  begin n_o++; if (i_o < 0) i_o = k; end
            if (cmd_valid && !pv && i_r < 0) i_r = k;
            pv = cmd_valid;
            if (v.hold > 0 && k == c_flen + v.hold - 1) check({tag, " busy_in_break"}, int'(busy), 1);
            if (k == v.rdy_k) cmd_ready = 1'b1;
            RxD = bitval(v, k);
            @(negedge clk);
        end
        check({tag, " frame_err"}, pulse_sig(n_f, i_f), v.e_ferr ? c_stop_idx : -1);
        check({tag, " bad_cmd"},   pulse_sig(n_b, i_b), v.e_bad  ? c_stop_idx + 1 : -1);
        check({tag, " overflow"},  pulse_sig(n_o, i_o), v.e_ovf  ? c_stop_idx + 2 : -1);
        check({tag, " valid_rise"}, i_r, v.e_rise ? c_stop_idx + 2 : -1);
        check({tag, " cmd_valid"}, int'(cmd_valid), int'(v.e_valid));
        check({tag, " opcode"},    int'(opcode), int'(v.e_op));
        check({tag, " busy_idle"}, int'(busy), 0);
        if (v.consume) begin
            cmd_ready = 1'b1;
            @(negedge clk);
            cmd_ready = 1'b0;
            check({tag, " consumed_valid"}, int'(cmd_valid), 0);
            check({tag, " consumed_opcode"}, int'(opcode), int'(v.e_op));
        end
    endtask

    initial begin
        vec_t v;
        int   g_busy, g_pulse, g_valid;

        //            data  stop bp rdy hold rdy_k           cons ferr bad ovf rise valid op
        tbl[0] = mk(8'h32, 1, 0, 0, 0,  -1,             1, 0, 0, 0, 1, 1, 2'd2);
        tbl[1] = mk(8'h31, 1, 0, 0, 0,  -1,             0, 0, 0, 0, 1, 1, 2'd1);
        tbl[2] = mk(8'h33, 1, 0, 0, 0,  -1,             1, 0, 0, 1, 0, 1, 2'd1);
        tbl[3] = mk(8'h41, 1, 0, 0, 0,  -1,             0, 0, 1, 0, 0, 0, 2'd1);
        tbl[4] = mk(8'h55, 0, 0, 0, 40, -1,             0, 1, 0, 0, 0, 0, 2'd1);
        tbl[5] = mk(8'h30, 1, 0, 0, 0,  -1,             1, 0, 0, 0, 1, 1, 2'd0);
        tbl[6] = mk(8'h33, 1, 0, 1, 0,  -1,             0, 0, 0, 0, 1, 0, 2'd3);
        tbl[7] = mk(8'h30, 1, 0, 0, 0,  -1,             0, 0, 0, 0, 1, 1, 2'd0);
        tbl[8] = mk(8'h31, 1, 0, 0, 0,  c_stop_idx + 1, 0, 0, 0, 0, 0, 0, 2'd1);
        tbl[9] = mk(8'h32, 1, 0, 1, 0,  -1,             0, 0, 0, 0, 1, 0, 2'd2);

        // Reset state
        rst_n = 1'b0;
        RxD   = 1'b1;
        repeat (4) @(negedge clk);
        check("rst opcode", int'(opcode), 0);
        check("rst cmd_valid", int'(cmd_valid), 0);
        check("rst busy", int'(busy), 0);
        check("rst pulses", int'(frame_err) + int'(bad_cmd) + int'(overflow), 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Hand-derived frame table
        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
        m_valid = 1'b0;
        m_op    = 2'd2;

        // Five-clock low glitch while idle
        g_busy = 0; g_pulse = 0; g_valid = 0;
        RxD = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy) g_busy = 1;
            if (frame_err || bad_cmd || overflow) g_pulse++;
            if (cmd_valid) g_valid++;
            if (k == 5) RxD = 1'b1;
            @(negedge clk);
        end
        check("glitch busy_seen", g_busy, 1);
        check("glitch pulses", g_pulse, 0);
        check("glitch valid_cycles", g_valid, 0);
        check("glitch busy_end", int'(busy), 0);

        // Randomized frames against the model
        for (int i = 0; i < 24; i++) begin
            v.data    = ($urandom_range(0, 1) == 1) ? (8'h30 + 8'($urandom_range(0, 3))) : 8'($urandom);
            v.stopb   = ($urandom_range(0, 7) != 0);
            v.badpar  = c_par && ($urandom_range(0, 5) == 0);
            v.ready   = ($urandom_range(0, 2) == 0);
            v.hold    = 0;
            v.rdy_k   = -1;
            v.consume = ($urandom_range(0, 1) == 1);
            v = model(v);
            run_vec(v, $sformatf("rand%0d", i));
        end

        // Reset in the middle of DATA with a pending opcode
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        m_valid   = 1'b0;
        v = model(mk(8'h32, 1, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0, 2'd0));
        run_vec(v, "pre_rst");
        v = mk(8'hA5, 1, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0, 2'd0);
        for (int k = 0; k < 60; k++) begin
            RxD = bitval(v, k);
            @(negedge clk);
        end
        rst_n = 1'b0;
        RxD   = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst opcode", int'(opcode), 0);
        check("midrst cmd_valid", int'(cmd_valid), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst pulses", int'(frame_err) + int'(bad_cmd) + int'(overflow), 0);
        rst_n  = 1'b1;
        g_busy = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy || frame_err) g_busy = 1;
            @(negedge clk);
        end
        check("low line after reset not a start", g_busy, 0);
        RxD = 1'b1;
        repeat (8) @(negedge clk);
        m_valid = 1'b0;
        m_op    = 2'd0;
        v = model(mk(8'h33, 1, 0, 0, 0, -1, 1, 0, 0, 0, 0, 0, 2'd0));
        run_vec(v, "post_rst");

`ifdef UART_CMD_RX_PARITY_EN
        run_vec(mk(8'h31, 1, 0, 0, 0, -1, 1, 0, 0, 0, 1, 1, 2'd1), "par_good");
        run_vec(mk(8'h31, 1, 1, 0, 0, -1, 0, 1, 0, 0, 0, 0, 2'd1), "par_bad");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
